nibble_result_reader: RTL and testbench
=======================================

NIBBLE_RESULT_READER -- requirements
Module: nibble_result_reader

Interface
REQ-001 The block SHALL have parameter DB_CYCLES, default 16, giving the number of consecutive stable clk cycles needed to accept a pb_next level change.
REQ-002 The block SHALL have port clk, input, 1 bit: the single clock; all state SHALL be on its rising edge.
REQ-003 The block SHALL have port rst, input, 1 bit: reset, asynchronous and active-high.
REQ-004 The block SHALL have port load, input, 1 bit: synchronous one-cycle capture strobe.
REQ-005 The block SHALL have port result, input, 8 bits: {cout, sum[6:0]} from the adder, sampled only when load=1.
REQ-006 The block SHALL have port pb_next, input, 1 bit: raw asynchronous pushbutton that advances the displayed nibble.
REQ-007 The block SHALL have port led, output, 4 bits: the displayed nibble (registered).
REQ-008 The block SHALL have port led_sel, output, 1 bit: 0 = low nibble shown, 1 = high nibble shown (registered).
REQ-009 The block SHALL have port busy, output, 1 bit: high in SHOW_LO and SHOW_HI.
REQ-010 The block SHALL have port done, output, 1 bit: high in DONE.

Function
REQ-011 pb_next SHALL pass through a 2-flop synchronizer before any other use.
REQ-012 Debounce: a counter SHALL restart on every synchronized-level change; the debounced level SHALL take the synchronized value only after DB_CYCLES stable cycles.
REQ-013 A press SHALL be a one-cycle pulse on a 0->1 transition of the debounced level; a release SHALL generate no event.
REQ-014 The FSM SHALL have states IDLE, SHOW_LO, SHOW_HI and DONE.
REQ-015 In any state, load=1 SHALL capture result into an 8-bit shadow register and set the next state to SHOW_LO.
REQ-016 A press SHALL cause SHOW_LO->SHOW_HI, SHOW_HI->DONE and DONE->SHOW_LO (replay of the same shadow value); a press in IDLE SHALL be ignored.
REQ-017 If load and a press occur in the same cycle, load SHALL win and the press SHALL be discarded.
REQ-018 Outputs SHALL be decoded from the state and registered:
- IDLE and DONE: led=0, led_sel=0.
- SHOW_LO: led=shadow[3:0], led_sel=0.
- SHOW_HI: led=shadow[7:4], led_sel=1.
REQ-019 Latency from a load cycle SHALL be 1 cycle: outputs reflect the new shadow value on the edge after load is sampled.
REQ-020 Latency from a clean pb_next rise SHALL be 2 (sync) + DB_CYCLES + 1 (FSM) cycles, each ±1 for asynchronous sampling.
REQ-021 Bounces shorter than DB_CYCLES SHALL produce no press; a held button SHALL produce exactly one press.
REQ-022 result SHALL be ignored while load=0; the shadow register SHALL hold its value until the next load.

Reset
REQ-023 While rst=1, state SHALL be IDLE, shadow=0, led=0, led_sel=0, busy=0, done=0, synchronizer flops=0, debounce counter=0 and debounced level=0.
REQ-024 rst asserted mid-display SHALL abort to IDLE immediately, without waiting for a clock edge.
REQ-025 A button held through reset release SHALL yield one press after the debounce time; in IDLE that press is ignored per REQ-016.

Structure
REQ-026 A shared package SHALL hold the FSM state encoding (IDLE, SHOW_LO, SHOW_HI, DONE) and the DB_CYCLES default constant.
REQ-027 The synchronizer, debounce and edge-detect logic SHALL form one sub-module, pb_debounce (ports: clk, rst, raw, press), reusable for the operand-load buttons.
REQ-028 The debounce counter width SHALL be the minimum that holds DB_CYCLES.

Verification (bench uses DB_CYCLES=4)
REQ-029 Reset, then load with result=8'hA5 -> next cycle led=4'h5, led_sel=0, busy=1, done=0.
REQ-030 From REQ-029, one clean press, then another -> led=4'hA, led_sel=1; then led=0, done=1, busy=0.
REQ-031 In DONE, a third press -> SHOW_LO with led=4'h5, replaying the same shadow value.
REQ-032 pb_next pulses of 1-3 cycles separated by gaps of 1-3 cycles, then held high for 10 cycles -> exactly one state advance.
REQ-033 load with result=8'h3C in the same cycle as a press pulse while in SHOW_HI -> SHOW_LO, led=4'hC, press discarded.
REQ-034 rst asserted between clock edges while in SHOW_HI -> all outputs 0 before the next edge; after release, a press leaves the block in IDLE.

Source files
------------

// File: rtl/nibble_result_reader_pkg.sv
// Shared definitions for the nibble result reader: FSM state encoding,
// debounce default and the display decode used by the top level.
package nibble_result_reader_pkg;

  // Default number of stable clocks before a button level change is accepted.
  localparam int DB_CYCLES_DEF = 16;

  // FSM state encoding.
  localparam logic [1:0] ST_IDLE    = 2'd0;
  localparam logic [1:0] ST_SHOW_LO = 2'd1;
  localparam logic [1:0] ST_SHOW_HI = 2'd2;
  localparam logic [1:0] ST_DONE    = 2'd3;

  // Everything the block presents to the outside world, in one bundle.
  typedef struct packed {
    logic [3:0] led;
    logic       led_sel;
    logic       busy;
    logic       done;
  } disp_t;

  // Where a button press takes each state; IDLE has nothing loaded to show.
  function automatic logic [1:0] press_next(input logic [1:0] st);
    logic [1:0] nxt;
    nxt = st;
    case (st)
      ST_SHOW_LO: nxt = ST_SHOW_HI;
      ST_SHOW_HI: nxt = ST_DONE;
      ST_DONE:    nxt = ST_SHOW_LO;
      default:    nxt = ST_IDLE;
    endcase
    return nxt;
  endfunction

  // Display contents for a given state and captured result.
  function automatic disp_t disp_decode(input logic [1:0] st, input logic [7:0] shadow);
    disp_t d;
    d = '0;
    case (st)
      ST_SHOW_LO: begin
        d.led  = shadow[3:0];
        d.busy = 1'b1;
      end
      ST_SHOW_HI: begin
        d.led     = shadow[7:4];
        d.led_sel = 1'b1;
        d.busy    = 1'b1;
      end
      ST_DONE: d.done = 1'b1;
      default: d = '0;
    endcase
    return d;
  endfunction

endpackage

// File: rtl/nibble_result_reader_if.sv
// Bus between the adder/pushbutton side and the result reader.
interface nibble_result_reader_if;

  logic       load;
  logic [7:0] result;
  logic       pb_next;
  logic [3:0] led;
  logic       led_sel;
  logic       busy;
  logic       done;

  // Stimulus side: provides the capture strobe, result and raw button.
  modport master (
    output load,
    output result,
    output pb_next,
    input  led,
    input  led_sel,
    input  busy,
    input  done
  );

  // Reader side.
  modport slave (
    input  load,
    input  result,
    input  pb_next,
    output led,
    output led_sel,
    output busy,
    output done
  );

endinterface

// File: rtl/nibble_result_reader_pb_debounce.sv
// Pushbutton conditioner: 2-flop synchronizer, level debounce and a
// single-cycle pulse on each accepted press (release produces nothing).
module pb_debounce
  import nibble_result_reader_pkg::*;
#(
  parameter int DB_CYCLES = DB_CYCLES_DEF
) (
  input  logic clk,
  input  logic rst,
  input  logic raw,
  output logic press
);

  // Narrowest counter that can represent DB_CYCLES.
  localparam int              CNT_W    = $clog2(DB_CYCLES + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DB_CYCLES - 1);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

  logic             r_sync0;
  logic             r_sync1;
  logic [CNT_W-1:0] r_cnt;
  logic             r_db;
  logic             r_db_q;

  // Bring the asynchronous button into the clock domain.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_sync0 <= 1'b0;
      r_sync1 <= 1'b0;
    end else begin
      r_sync0 <= raw;
      r_sync1 <= r_sync0;
    end
  end

  // Count consecutive cycles the synchronized level differs from the accepted
  // level; any return to the accepted level restarts the count.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_cnt <= '0;
      r_db  <= 1'b0;
    end else if (r_sync1 == r_db) begin
      r_cnt <= '0;
    end else if (r_cnt == CNT_LAST) begin
      r_cnt <= '0;
      r_db  <= r_sync1;
    end else begin
      r_cnt <= r_cnt + CNT_ONE;
    end
  end

  // Remember last cycle's accepted level for rising-edge detection.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_db_q <= 1'b0;
    end else begin
      r_db_q <= r_db;
    end
  end

  assign press = r_db & ~r_db_q;

endmodule

// File: rtl/nibble_result_reader.sv
// Captures an 8-bit adder result on load and shows it one nibble at a time
// on four LEDs, stepping low -> high -> done -> low with a debounced button.
module nibble_result_reader
  import nibble_result_reader_pkg::*;
#(
  parameter int DB_CYCLES = DB_CYCLES_DEF
) (
  input  logic                         clk,
  input  logic                         rst,
  nibble_result_reader_if.slave        bus
);

  logic       w_press;
  logic [1:0] r_state;
  logic [1:0] w_state_nxt;
  logic [7:0] r_shadow;
  logic [7:0] w_shadow_nxt;
  disp_t      w_disp_nxt;
  disp_t      r_disp;

  pb_debounce #(
    .DB_CYCLES (DB_CYCLES)
  ) u_pb_next (
    .clk   (clk),
    .rst   (rst),
    .raw   (bus.pb_next),
    .press (w_press)
  );

  // Next state and shadow: a load always wins over a simultaneous press.
  always_comb begin
    w_state_nxt  = r_state;
    w_shadow_nxt = r_shadow;
    if (bus.load) begin
      w_shadow_nxt = bus.result;
      w_state_nxt  = ST_SHOW_LO;
    end else if (w_press) begin
      w_state_nxt  = press_next(r_state);
    end
  end

  // Outputs are decoded from the next state so they change on the same edge
  // as the state register rather than one cycle later.
  assign w_disp_nxt = disp_decode(w_state_nxt, w_shadow_nxt);

  // State and captured result.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state  <= ST_IDLE;
      r_shadow <= '0;
    end else begin
      r_state  <= w_state_nxt;
      r_shadow <= w_shadow_nxt;
    end
  end

  // Registered display outputs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_disp <= '0;
    end else begin
      r_disp <= w_disp_nxt;
    end
  end

  assign bus.led     = r_disp.led;
  assign bus.led_sel = r_disp.led_sel;
  assign bus.busy    = r_disp.busy;
  assign bus.done    = r_disp.done;

endmodule

// File: tb/tb_nibble_result_reader.sv
// Bench for nibble_result_reader with DB_CYCLES=4: directed scenarios plus
// randomized button/load traffic, compared every cycle to a reference model.
module tb_nibble_result_reader;

  localparam int DB = 4;

  localparam int M_IDLE = 0;
  localparam int M_LO   = 1;
  localparam int M_HI   = 2;
  localparam int M_DONE = 3;

  logic clk;
  logic rst;

  nibble_result_reader_if bus ();

  nibble_result_reader #(
    .DB_CYCLES (DB)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_err = 0;

  // Reference model state
  int         m_st;
  logic [7:0] m_shadow;
  bit         m_db;
  bit         m_db_prev;
  bit         m_raw[$];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s @%0t: got %0h expected %0h", tag, $time, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_st      = M_IDLE;
    m_shadow  = 8'h00;
    m_db      = 1'b0;
    m_db_prev = 1'b0;
    m_raw.delete();
    for (int i = 0; i < DB + 2; i++) m_raw.push_back(1'b0);
  endtask

  task automatic check_outputs(input string where);
    logic [3:0] e_led;
    logic       e_sel;
    logic       e_busy;
    logic       e_done;
    e_led  = 4'h0;
    e_sel  = 1'b0;
    e_busy = (m_st == M_LO) || (m_st == M_HI);
    e_done = (m_st == M_DONE);
    if (m_st == M_LO) e_led = m_shadow[3:0];
    if (m_st == M_HI) begin
      e_led = m_shadow[7:4];
      e_sel = 1'b1;
    end
    chk({where, ".led"},     bus.led,     e_led);
    chk({where, ".led_sel"}, bus.led_sel, e_sel);
    chk({where, ".busy"},    bus.busy,    e_busy);
    chk({where, ".done"},    bus.done,    e_done);
  endtask

  // One clock: advance the model with the inputs seen at the rising edge,
  // then compare on the falling edge.
  task automatic tick(input string where = "cyc");
    bit press;
    bit same;
    bit v;
    int sz;
    @(posedge clk);
    if (rst) begin
      model_reset();
    end else begin
      press = m_db && !m_db_prev;
      m_db_prev = m_db;
      // The debounced level follows the synchronized button once the last DB
      // synchronized samples (raw delayed two clocks) all agree on a new value.
      sz   = m_raw.size();
      v    = m_raw[sz - 2];
      same = 1'b1;
      for (int k = 0; k < DB; k++) if (m_raw[sz - 2 - k] != v) same = 1'b0;
      if (same && v != m_db) m_db = v;
      m_raw.push_back(bus.pb_next);
      void'(m_raw.pop_front());
      if (bus.load) begin
        m_shadow = bus.result;
        m_st     = M_LO;
      end else if (press) begin
        case (m_st)
          M_LO:    m_st = M_HI;
          M_HI:    m_st = M_DONE;
          M_DONE:  m_st = M_LO;
          default: m_st = M_IDLE;
        endcase
      end
    end
    @(negedge clk);
    check_outputs(where);
  endtask

  task automatic ticks(input int n, input string where = "cyc");
    for (int i = 0; i < n; i++) tick(where);
  endtask

  // Clean press: held well past the debounce time, then released just as long.
  task automatic press_clean();
    bus.pb_next = 1'b1;
    ticks(8, "press_hi");
    bus.pb_next = 1'b0;
    ticks(8, "press_lo");
  endtask

  initial begin
    int run;
    bit lvl;

    bus.load    = 1'b0;
    bus.result  = 8'h00;
    bus.pb_next = 1'b0;
    rst         = 1'b1;
    model_reset();

    // Reset state
    #1;
    chk("rst.led",     bus.led,     4'h0);
    chk("rst.led_sel", bus.led_sel, 1'b0);
    chk("rst.busy",    bus.busy,    1'b0);
    chk("rst.done",    bus.done,    1'b0);
    ticks(2, "rst");
    rst = 1'b0;
    ticks(3, "idle");

    // Load A5: low nibble shown on the very next edge
    bus.load   = 1'b1;
    bus.result = 8'hA5;
    tick("load_a5");
    bus.load   = 1'b0;
    bus.result = 8'h5A;
    chk("a5.led",     bus.led,     4'h5);
    chk("a5.led_sel", bus.led_sel, 1'b0);
    chk("a5.busy",    bus.busy,    1'b1);
    chk("a5.done",    bus.done,    1'b0);

    press_clean();
    chk("p1.led",     bus.led,     4'hA);
    chk("p1.led_sel", bus.led_sel, 1'b1);
    chk("p1.busy",    bus.busy,    1'b1);

    press_clean();
    chk("p2.led",  bus.led,  4'h0);
    chk("p2.done", bus.done, 1'b1);
    chk("p2.busy", bus.busy, 1'b0);

    // Replay from DONE
    press_clean();
    chk("p3.led",     bus.led,     4'h5);
    chk("p3.led_sel", bus.led_sel, 1'b0);
    chk("p3.busy",    bus.busy,    1'b1);

    // Bounces shorter than the debounce time, then a long hold: one advance
    for (int i = 0; i < 6; i++) begin
      bus.pb_next = 1'b1;
      ticks($urandom_range(1, 3), "bounce");
      bus.pb_next = 1'b0;
      ticks($urandom_range(1, 3), "bounce");
    end
    bus.pb_next = 1'b1;
    ticks(10, "hold");
    bus.pb_next = 1'b0;
    ticks(10, "release");
    chk("bnc.led",     bus.led,     4'hA);
    chk("bnc.led_sel", bus.led_sel, 1'b1);
    chk("bnc.done",    bus.done,    1'b0);

    // Load coinciding with the press pulse in SHOW_HI: load wins
    bus.pb_next = 1'b1;
    ticks(6, "coinc_pre");
    bus.load   = 1'b1;
    bus.result = 8'h3C;
    tick("coinc");
    bus.load   = 1'b0;
    bus.result = 8'hFF;
    chk("coinc.led",     bus.led,     4'hC);
    chk("coinc.led_sel", bus.led_sel, 1'b0);
    chk("coinc.busy",    bus.busy,    1'b1);
    ticks(4, "coinc_hold");
    bus.pb_next = 1'b0;
    ticks(10, "coinc_rel");
    chk("coinc2.led",     bus.led,     4'hC);
    chk("coinc2.led_sel", bus.led_sel, 1'b0);

    // Asynchronous reset in SHOW_HI, between clock edges
    press_clean();
    chk("pre_ar.led_sel", bus.led_sel, 1'b1);
    #2 rst = 1'b1;
    #1;
    chk("ar.led",     bus.led,     4'h0);
    chk("ar.led_sel", bus.led_sel, 1'b0);
    chk("ar.busy",    bus.busy,    1'b0);
    chk("ar.done",    bus.done,    1'b0);
    model_reset();
    tick("ar_hold");
    rst = 1'b0;
    press_clean();
    chk("ar_press.busy", bus.busy, 1'b0);
    chk("ar_press.done", bus.done, 1'b0);
    chk("ar_press.led",  bus.led,  4'h0);

    // Button held through reset release: its press lands in IDLE
    bus.pb_next = 1'b1;
    rst = 1'b1;
    model_reset();
    ticks(2, "held_rst");
    rst = 1'b0;
    ticks(12, "held_rel");
    chk("held.busy", bus.busy, 1'b0);
    chk("held.done", bus.done, 1'b0);
    bus.pb_next = 1'b0;
    ticks(10, "held_up");

    // Randomized traffic
    run = 0;
    lvl = 1'b0;
    for (int i = 0; i < 600; i++) begin
      if (run == 0) begin
        lvl = ~lvl;
        run = $urandom_range(1, 9);
      end
      run--;
      bus.pb_next = lvl;
      bus.load    = ($urandom_range(0, 15) == 0);
      bus.result  = 8'($urandom);
      tick("rnd");
    end
    bus.load = 1'b0;

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
